// File: rtl/io_stim_pkg.sv
// Shared types and constants for the io_stim_capture stimulus/response engine.
package io_stim_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } stim_state_t;

    // Feedback taps at bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [15:0] fix_seed(input logic [15:0] seed);
        return (seed == 16'h0000) ? 16'h0001 : seed;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit shift-left Fibonacci LFSR with parallel load and a 4-bit XOR-in port,
// serving both as the stimulus generator (din = 0) and as the response MISR.
module lfsr16
    import io_stim_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic        en,
    input  logic [3:0]  din,
    output logic [15:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= {q[14:0], ^(q & LFSR_TAPS)} ^ {12'b0, din};
        end
    end

endmodule

// File: rtl/io_stim_capture.sv
// Drives a seeded pseudo-random stimulus into an IO-wrapped DUT and compresses
// its four outputs into a 16-bit signature, one pass/fail word per run.
module io_stim_capture
    import io_stim_pkg::*;
#(
    parameter logic [15:0] SEED         = 16'hACE1,
    parameter int          NUM_VECTORS  = 256,
    parameter int          RST_CYCLES   = 4,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        dut_rst,
    output logic        dut_cen,
    output logic        dut_ina,
    output logic        dut_inb,
    input  logic [3:0]  dut_out,
    output logic [15:0] signature,
    output logic [15:0] vec_count,
    output stim_state_t dbg_state
);

    localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);
    localparam logic [15:0] RUN_LAST   = 16'(NUM_VECTORS - 1);
    localparam logic [15:0] RUN_MAX    = 16'(NUM_VECTORS);
    localparam logic [15:0] DRAIN_LAST = 16'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    stim_state_t state, state_next;
    logic [15:0] phase_cnt;
    logic [15:0] stim;
    logic [3:0]  sync1, smp;
    logic        enter_reset;
    logic        busy_d, done_d, dut_rst_d;
    logic        unused_stim;

    assign dbg_state   = state;
    assign unused_stim = ^stim[15:4];

    // State register; phase_cnt counts cycles spent in the current state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dut_rst   <= 1'b1;
            vec_count <= '0;
        end else begin
            state     <= state_next;
            phase_cnt <= (state_next != state) ? '0 : phase_cnt + 16'd1;
            busy      <= busy_d;
            done      <= done_d;
            dut_rst   <= dut_rst_d;
            if (enter_reset) begin
                vec_count <= '0;
            end else if (state == ST_RUN && vec_count != RUN_MAX) begin
                vec_count <= vec_count + 16'd1;
            end
        end
    end

    // dut_out is asynchronous to the stimulus, so it is resynchronised first.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            smp   <= '0;
        end else begin
            sync1 <= dut_out;
            smp   <= sync1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: if (start) state_next = ST_RESET;
            ST_RESET: if (phase_cnt == RST_LAST) state_next = ST_RUN;
            ST_RUN: begin
                if (phase_cnt == RUN_LAST) begin
                    state_next = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: if (phase_cnt == DRAIN_LAST) state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Registered status is decoded from the next state; stimulus is one gate from the LFSR.
    always_comb begin
        enter_reset = (state_next == ST_RESET) && (state != ST_RESET);
        busy_d      = (state_next == ST_RESET) || (state_next == ST_RUN) || (state_next == ST_DRAIN);
        done_d      = (state_next == ST_DONE);
        dut_rst_d   = (state_next == ST_IDLE) || (state_next == ST_RESET);
        dut_ina     = (state == ST_RUN) && stim[0];
        dut_inb     = (state == ST_RUN) && stim[1];
        dut_cen     = (state == ST_RUN) && (stim[2] || stim[3]);
    end

    lfsr16 u_stim_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load     (enter_reset),
        .load_val (fix_seed(SEED)),
        .en       (state == ST_RUN),
        .din      (4'b0000),
        .q        (stim)
    );

    lfsr16 u_misr (
        .clk      (clk),
        .rst      (rst),
        .load     (enter_reset),
        .load_val (16'h0000),
        .en       ((state == ST_RUN) || (state == ST_DRAIN)),
        .din      (smp),
        .q        (signature)
    );

endmodule

// File: doc/io_stim_capture.md
# io_stim_capture

Pin-level stimulus and response engine for the ice40 pack-test designs. It drives the input side of an IO-wrapped DUT (`rst`, `cen`, `ina`, `inb`) with a seeded pseudo-random sequence. It compresses the DUT's four outputs (`outa`..`outd`) into a 16-bit signature. On hardware it sits on the fabric side opposite the DUT's SB_IO pins and gives one pass/fail word per run.

## Interface

Parameters:
- `SEED`, 16'hACE1: stimulus LFSR seed. A value of 0 is replaced by 16'h0001.
- `NUM_VECTORS`, 256: number of RUN cycles, range 1..65535.
- `RST_CYCLES`, 4: number of cycles the DUT reset is held per run, minimum 1.
- `DRAIN_CYCLES`, 4: number of post-stimulus capture cycles, minimum 0.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  starts a run; sampled only in IDLE and DONE.
- `busy`  out  1  high in RESET, RUN and DRAIN.
- `done`  out  1  high in DONE (level, not a pulse).
- `dut_rst`  out  1  DUT reset.
- `dut_cen`  out  1  DUT clock enable.
- `dut_ina`  out  1  DUT data input a.
- `dut_inb`  out  1  DUT data input b.
- `dut_out`  in  4  DUT outputs `{outd,outc,outb,outa}`; asynchronous to stimulus.
- `signature`  out  16  MISR value; stable in DONE.
- `vec_count`  out  16  number of RUN cycles completed in the current run.

## Operation

- FSM states:
  - IDLE: on `start`, go to RESET.
  - RESET: lasts `RST_CYCLES`, then RUN.
  - RUN: lasts `NUM_VECTORS`, then DRAIN, or DONE if `DRAIN_CYCLES`=0.
  - DRAIN: lasts `DRAIN_CYCLES`, then DONE.
  - DONE: on `start`, go to RESET.
- `start` while `busy` is ignored.
- Reset values of outputs:
  - `busy`=0, `done`=0, `dut_rst`=1, `dut_cen`=0, `dut_ina`=0, `dut_inb`=0.
  - `signature`=0, `vec_count`=0.
  - State is IDLE.
- `dut_rst` by state:
  - 1 in IDLE and RESET.
  - 0 in RUN, DRAIN and DONE.
- Stimulus LFSR:
  - Loaded with `SEED` on entry to RESET.
  - 16-bit Fibonacci LFSR, shift left, `fb = l[15]^l[13]^l[12]^l[10]`, `l <= {l[14:0],fb}`.
  - Advances once per RUN cycle.
- Stimulus outputs in RUN are combinational from the current LFSR value:
  - `dut_ina = l[0]`
  - `dut_inb = l[1]`
  - `dut_cen = l[2] | l[3]`
- Outside RUN, `dut_ina`, `dut_inb` and `dut_cen` are all 0.
- `vec_count`:
  - Cleared on entry to RESET.
  - Increments at the end of each RUN cycle.
  - Saturates at `NUM_VECTORS`.
- Response path:
  - `dut_out` passes through a 2-flop synchronizer that runs continuously.
  - The synchronizer output is `smp[3:0]`.
- MISR:
  - Cleared on entry to RESET.
  - Updates in every RUN and DRAIN cycle: `m <= {m[14:0], m[15]^m[13]^m[12]^m[10]} ^ {12'b0, smp}`.
  - Holds in all other states.
- `signature` = m.
- `rst` asserted mid-run: next cycle is IDLE with all outputs at their reset values. There is no partial signature.

## Timing

- `start` high in IDLE at cycle t gives `busy`=1 and `dut_rst`=1 at t+1.
- `busy` stays high for exactly `RST_CYCLES + NUM_VECTORS + DRAIN_CYCLES` cycles.
- `done` rises in the cycle after the last busy cycle.
- The first RUN cycle presents stimulus from `SEED`.
- Response latency from `dut_out` to the MISR input is 2 cycles.
- DRAIN exists so that DUT output for the last vectors is captured.
- All outputs are registered except the stimulus decode, which is one gate level from the LFSR register.

## Structure

- Package `io_stim_pkg` holds:
  - the state enum `stim_state_t`;
  - `LFSR_TAPS` = 16'hB400 (bits 15, 13, 12, 10);
  - the zero-seed substitution function.
- Sub-module `lfsr16`:
  - Ports: `clk`, `rst`, `load`, `load_val`, `en`, `din[3:0]`, `q[15:0]`.
  - Instantiated twice: as the stimulus LFSR with `din`=0, and as the MISR with `din`=`smp`.
- The FSM, counters and synchronizer live in the top module.

## Test plan

- Defaults, `dut_out` tied to 4'b0000 → `busy` high for exactly 264 cycles; `done`=1; `vec_count`=256; `signature`=16'h0000.
- Defaults, first RUN cycle → `dut_ina`=1, `dut_inb`=0, `dut_cen`=0 (`SEED` 0xACE1).
- `NUM_VECTORS`=1, `DRAIN_CYCLES`=0, `dut_out` held at 4'b0001 from reset → `signature`=16'h0001 in DONE.
- `rst` pulsed at `vec_count`=100 → next cycle: IDLE, `busy`=0, `done`=0, `signature`=0, `dut_rst`=1, `dut_cen`=0.
- `start` pulsed while `busy` → no effect on the cycle count. `start` in DONE with the DUT model unchanged → second run gives a `signature` identical to the first.
- `SEED`=0 → LFSR loads 16'h0001; the first RUN cycle gives `dut_ina`=1, `dut_inb`=0, `dut_cen`=0, and the sequence never locks up.
